key_entry_ctrl: RTL

- Sequencer between the PS/2 scancode receiver and the number datapath.
- Decodes make, break (F0) and extended (E0) prefixes, and suppresses typematic repeats.
- Accumulates decimal digits as packed BCD with backspace, clear and enter editing.
- Hands the committed number to the consumer over a valid/ready handshake.

---
 rtl/key_entry_ctrl_pkg.sv | 38 +++
 rtl/key_entry_ctrl_bcd2bin_seq.sv | 55 +++++
 rtl/key_entry_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/key_entry_ctrl_pkg.sv
// Shared scancode constants, prefix-decoder states and digit mapping
// for the keypad entry sequencer.
package key_entry_pkg;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        PFX_NONE,
        PFX_BRK,
        PFX_EXT,
        PFX_EXTBRK
    } pfx_e;

    // {is_digit, value}
    function automatic logic [4:0] sc_to_digit(input logic [7:0] sc);
        logic [4:0] r;
        r = 5'h00;
        case (sc)
            8'h45:   r = 5'h10;
            8'h16:   r = 5'h11;
            8'h1E:   r = 5'h12;
            8'h26:   r = 5'h13;
            8'h25:   r = 5'h14;
            8'h2E:   r = 5'h15;
            8'h36:   r = 5'h16;
            8'h3D:   r = 5'h17;
            8'h3E:   r = 5'h18;
            8'h46:   r = 5'h19;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_entry_ctrl_bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one nibble per cycle,
// most-significant nibble first; done pulses after DIGITS cycles.
module bcd2bin_seq
    import key_entry_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  done,
    output logic [BIN_W-1:0]      bin
);

    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [NW-1:0]    sreg;
    logic [CW-1:0]    left;
    logic             run;
    logic [BIN_W-1:0] acc_x10;

    assign acc_x10 = (bin << 3) + (bin << 1);

    // The first nibble is folded in on the start edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            left <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            bin  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin  <= BIN_W'(bcd[NW-1 -: 4]);
                sreg <= bcd << 4;
                left <= CW'(DIGITS - 1);
                run  <= (DIGITS > 1);
                done <= (DIGITS == 1);
            end else if (run) begin
                bin  <= acc_x10 + BIN_W'(sreg[NW-1 -: 4]);
                sreg <= sreg << 4;
                left <= left - CW'(1);
                if (left == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/key_entry_ctrl.sv
// PS/2 keypad entry sequencer: prefix decode, repeat filter, BCD editing,
// valid/ready commit. Define BINARY_CONV_EN to add the binary conversion.
module key_entry_ctrl
    import key_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 8,
    parameter int BIN_W      = 27
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sc_valid,
    input  logic [7:0]                        sc_data,
    output logic [4*MAX_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   entry_cnt,
    output logic                              ovf,
    output logic                              num_valid,
    input  logic                              num_ready,
    output logic [4*MAX_DIGITS-1:0]           num_bcd,
    output logic [BIN_W-1:0]                  num_bin,
    output logic                              busy
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    pfx_e       pfx;
    pfx_e       pfx_nxt;
    logic [7:0] last_make;
    logic [7:0] tag;
    logic [4:0] dig;
    logic       mk;
    logic       rel;
    logic       ext;
    logic       fresh;
    logic       act;
    logic       full;
    logic       empty;
    logic       is_dig;
    logic       is_bksp;
    logic       is_esc;
    logic       is_enter;
    logic       xfer;

    always_comb begin
        mk      = 1'b0;
        rel     = 1'b0;
        ext     = 1'b0;
        pfx_nxt = pfx;
        if (sc_valid) begin
            unique case (pfx)
                PFX_NONE: begin
                    if (sc_data == SC_BRK)
                        pfx_nxt = PFX_BRK;
                    else if (sc_data == SC_EXT)
                        pfx_nxt = PFX_EXT;
                    else
                        mk = 1'b1;
                end
                PFX_EXT: begin
                    ext = 1'b1;
                    if (sc_data == SC_BRK) begin
                        pfx_nxt = PFX_EXTBRK;
                    end else begin
                        mk      = 1'b1;
                        pfx_nxt = PFX_NONE;
                    end
                end
                default: begin
                    rel     = 1'b1;
                    ext     = (pfx == PFX_EXTBRK);
                    pfx_nxt = PFX_NONE;
                end
            endcase
        end
    end

    // Extended keys share the filter with bit 7 forced high.
    assign tag      = ext ? {1'b1, sc_data[6:0]} : sc_data;
    assign fresh    = mk && (tag != last_make);
    assign act      = fresh && !busy;
    assign dig      = sc_to_digit(sc_data);
    assign full     = (entry_cnt == CW'(MAX_DIGITS));
    assign empty    = (entry_cnt == '0);
    assign is_dig   = act && !ext && dig[4];
    assign is_bksp  = act && !ext && (sc_data == SC_BKSP);
    assign is_esc   = act && !ext && (sc_data == SC_ESC);
    assign is_enter = act && (sc_data == SC_ENTER) && !empty;
    assign xfer     = num_valid && num_ready;

`ifdef BINARY_CONV_EN
    logic             conv_done;
    logic [BIN_W-1:0] conv_bin;

    bcd2bin_seq #(
        .DIGITS (MAX_DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (is_enter),
        .bcd    (entry_bcd),
        .done   (conv_done),
        .bin    (conv_bin)
    );
`else
    assign num_bin = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pfx       <= PFX_NONE;
            last_make <= '0;
            entry_bcd <= '0;
            entry_cnt <= '0;
            ovf       <= 1'b0;
            num_valid <= 1'b0;
            num_bcd   <= '0;
            busy      <= 1'b0;
`ifdef BINARY_CONV_EN
            num_bin   <= '0;
`endif
        end else begin
            ovf <= 1'b0;
            pfx <= pfx_nxt;
            if (fresh)
                last_make <= tag;
            else if (rel && (tag == last_make))
                last_make <= '0;

            unique case (1'b1)
                is_dig && full: begin
                    ovf <= 1'b1;
                end
                is_dig && !full: begin
                    entry_bcd <= {entry_bcd[BW-5:0], dig[3:0]};
                    entry_cnt <= entry_cnt + CW'(1);
                end
                is_bksp && !empty: begin
                    entry_bcd <= {4'h0, entry_bcd[BW-1:4]};
                    entry_cnt <= entry_cnt - CW'(1);
                end
                is_esc: begin
                    entry_bcd <= '0;
                    entry_cnt <= '0;
                end
                is_enter: begin
                    num_bcd   <= entry_bcd;
                    entry_bcd <= '0;
                    entry_cnt <= '0;
                    busy      <= 1'b1;
`ifndef BINARY_CONV_EN
                    num_valid <= 1'b1;
`endif
                end
                default: ;
            endcase

            if (xfer) begin
                num_valid <= 1'b0;
                busy      <= 1'b0;
            end
`ifdef BINARY_CONV_EN
            if (conv_done) begin
                num_valid <= 1'b1;
                num_bin   <= conv_bin;
            end
`endif
        end
    end

endmodule
